// File: rtl/sobel_pkg.sv
// Shared constants, pixel word layout and channel expansion helpers for the Sobel path.
package sobel_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned GRAY_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PROD_W = 16;

    localparam logic [BYTE_W-1:0] GRAY_KR = 8'd77;
    localparam logic [BYTE_W-1:0] GRAY_KG = 8'd150;
    localparam logic [BYTE_W-1:0] GRAY_KB = 8'd29;

    localparam logic [CNT_W-1:0] CNT_COL_MAX_DEF = 16'd640;
    localparam logic [CNT_W-1:0] CNT_ROW_MAX_DEF = 16'd480;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Bit replication keeps full-scale channels at 8'hFF.
    function automatic logic [BYTE_W-1:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [BYTE_W-1:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/rgb565_to_gray.sv
// Two-stage RGB565 to 8-bit luma pipeline: weighted products, then sum and scale.
module rgb565_to_gray
    import sobel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [PIX_W-1:0]  in_pix,
    output logic              out_vld,
    output logic [GRAY_W-1:0] out_gray
);

    rgb565_t           pix_c;
    logic [PROD_W-1:0] pr_c;
    logic [PROD_W-1:0] pg_c;
    logic [PROD_W-1:0] pb_c;
    logic [PROD_W-1:0] sum_c;

    logic              vld_a;
    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] pg;
    logic [PROD_W-1:0] pb;

    assign pix_c = rgb565_t'(in_pix);
    assign pr_c  = PROD_W'(expand5(pix_c.r)) * PROD_W'(GRAY_KR);
    assign pg_c  = PROD_W'(expand6(pix_c.g)) * PROD_W'(GRAY_KG);
    assign pb_c  = PROD_W'(expand5(pix_c.b)) * PROD_W'(GRAY_KB);

    // Coefficients sum to 256, so the total peaks at 255*256 and fits 16 bits.
    assign sum_c = pr + pg + pb;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_a    <= 1'b0;
            pr       <= '0;
            pg       <= '0;
            pb       <= '0;
            out_vld  <= 1'b0;
            out_gray <= '0;
        end else begin
            vld_a   <= in_vld;
            out_vld <= vld_a;
            if (in_vld) begin
                pr <= pr_c;
                pg <= pg_c;
                pb <= pb_c;
            end
            if (vld_a) begin
                out_gray <= sum_c[PROD_W-1 -: GRAY_W];
            end
        end
    end

endmodule

// File: rtl/cmos_gray_capture.sv
// OV5640 DVP capture: frame skipping, byte pairing into RGB565, line checks and gray conversion.
module cmos_gray_capture
    import sobel_pkg::*;
#(
    parameter logic [3:0]       FRAME_SKIP  = 4'd10,
    parameter logic [CNT_W-1:0] CNT_COL_MAX = CNT_COL_MAX_DEF,
    parameter logic [CNT_W-1:0] CNT_ROW_MAX = CNT_ROW_MAX_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    output logic              dip_en,
    output logic [GRAY_W-1:0] dip_data,
    output logic              frame_done,
    output logic              line_err
);

    logic              vsync_d;
    logic              href_d;
    logic              first_rise_seen;
    logic [3:0]        frame_cnt;
    logic              phase;
    logic [BYTE_W-1:0] hi_byte;
    logic              pix_vld;
    logic [PIX_W-1:0]  pix565;
    logic [CNT_W-1:0]  col_cnt;
    logic [CNT_W-1:0]  row_cnt;
    logic              last_p;
    logic              last_a;

    logic              vs_rise_c;
    logic              href_fall_c;
    logic              cap_en_c;
    logic              pix_done_c;
    logic              last_c;
    logic              line_bad_c;

    assign vs_rise_c   = cam_vsync & ~vsync_d;
    assign href_fall_c = href_d & ~cam_href;
    assign cap_en_c    = (frame_cnt == FRAME_SKIP);
    // A vsync rise kills the pixel whose low byte would land on that cycle.
    assign pix_done_c  = cam_href & phase & ~vs_rise_c;
    assign last_c      = cap_en_c & pix_done_c
                       & (CNT_W'(col_cnt + CNT_W'(1)) == CNT_COL_MAX)
                       & (CNT_W'(row_cnt + CNT_W'(1)) == CNT_ROW_MAX);
    assign line_bad_c  = (col_cnt != CNT_COL_MAX) | phase | (row_cnt >= CNT_ROW_MAX);

    // Sync edges, frame skipping, byte phase and line/frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d         <= 1'b0;
            href_d          <= 1'b0;
            first_rise_seen <= 1'b0;
            frame_cnt       <= '0;
            phase           <= 1'b0;
            hi_byte         <= '0;
            pix_vld         <= 1'b0;
            pix565          <= '0;
            col_cnt         <= '0;
            row_cnt         <= '0;
            last_p          <= 1'b0;
            last_a          <= 1'b0;
            frame_done      <= 1'b0;
            line_err        <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            pix_vld    <= pix_done_c & cap_en_c;
            last_p     <= last_c;
            last_a     <= last_p;
            frame_done <= last_a;
            if (pix_done_c) begin
                pix565 <= {hi_byte, cam_data};
            end
            if (vs_rise_c) begin
                // frame_cnt counts completed frames; the first rise only opens one.
                first_rise_seen <= 1'b1;
                if (first_rise_seen && (frame_cnt != FRAME_SKIP)) begin
                    frame_cnt <= frame_cnt + 4'd1;
                end
                phase    <= 1'b0;
                col_cnt  <= '0;
                row_cnt  <= '0;
                line_err <= 1'b0;
            end else begin
                phase <= cam_href & ~phase;
                if (cam_href && !phase) begin
                    hi_byte <= cam_data;
                end
                if (href_fall_c) begin
                    if (line_bad_c) begin
                        line_err <= 1'b1;
                    end
                    col_cnt <= '0;
                    if (row_cnt != '1) begin
                        row_cnt <= row_cnt + CNT_W'(1);
                    end
                end else if (pix_done_c && (col_cnt != '1)) begin
                    col_cnt <= col_cnt + CNT_W'(1);
                end
            end
        end
    end

    rgb565_to_gray u_gray (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (pix_vld),
        .in_pix   (pix565),
        .out_vld  (dip_en),
        .out_gray (dip_data)
    );

endmodule

// File: tb/tb_cmos_gray_capture.sv
// Self-checking bench for cmos_gray_capture with a transaction-level scoreboard model.
`timescale 1ns/1ps
module tb_cmos_gray_capture;

    localparam logic [3:0] SKIP = 4'd2;
    localparam int COLS = 4;
    localparam int ROWS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       dip_en;
    logic [7:0] dip_data;
    logic       frame_done;
    logic       line_err;

    cmos_gray_capture #(
        .FRAME_SKIP  (SKIP),
        .CNT_COL_MAX (16'(COLS)),
        .CNT_ROW_MAX (16'(ROWS))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .dip_en     (dip_en),
        .dip_data   (dip_data),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [7:0] gray;
        bit         last;
    } exp_t;

    typedef struct {
        logic [15:0] pix;
        logic [7:0]  gray;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecount  = 0;
    int   seen_cnt = 0;
    int   fd_cnt   = 0;

    // Model state: vsync rises since reset, lines ended in this frame, expected sticky error.
    int frames_seen = 0;
    int line_idx    = 0;
    bit model_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, ecount);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return 8'((r * 77 + g * 150 + b * 29) / 256);
    endfunction

    // Scoreboard: every dip_en must match the oldest expectation in edge and value.
    always @(posedge clk) begin
        #1;
        ecount++;
        while (exp_q.size() > 0 && exp_q[0].edge_n < ecount) begin
            check("pixel_emitted_on_time", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        if (dip_en) begin
            seen_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_dip_en", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dip_edge", ecount, mon_e.edge_n);
                check("dip_data", 32'(dip_data), 32'(mon_e.gray));
                check("frame_done_with_pixel", 32'(frame_done), 32'(mon_e.last));
            end
        end else if (frame_done) begin
            check("frame_done_without_dip_en", 32'd1, 32'd0);
        end
        if (frame_done) fd_cnt++;
    end

    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    // Called right after a low byte is driven: it is sampled at the next edge, emitted two later.
    task automatic push_exp(input logic [7:0] g, input bit last);
        exp_t e;
        e.edge_n = ecount + 3;
        e.gray   = g;
        e.last   = last;
        exp_q.push_back(e);
    endtask

    task automatic model_rise();
        frames_seen++;
        line_idx  = 0;
        model_err = 1'b0;
    endtask

    task automatic model_line_end(input int npix, input bit odd);
        if (npix != COLS || odd || line_idx >= ROWS) model_err = 1'b1;
        line_idx++;
    endtask

    task automatic start_frame();
        step(1'b1, 1'b0, 8'h00);
        model_rise();
        step(1'b1, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic send_line(input logic [15:0] pix[$], input bit odd_tail);
        for (int i = 0; i < pix.size(); i++) begin
            step(1'b0, 1'b1, pix[i][15:8]);
            step(1'b0, 1'b1, pix[i][7:0]);
            if (frames_seen > int'(SKIP))
                push_exp(ref_gray(pix[i]), (line_idx == ROWS - 1) && (i == COLS - 1));
        end
        if (odd_tail) step(1'b0, 1'b1, 8'($urandom));
        model_line_end(pix.size(), odd_tail);
        idle(3);
    endtask

    task automatic send_frame();
        logic [15:0] pl[$];
        start_frame();
        for (int l = 0; l < ROWS; l++) begin
            pl = {};
            repeat (COLS) pl.push_back(16'($urandom));
            send_line(pl, 1'b0);
        end
    endtask

    task automatic run_skip_test(input string tag);
        int s0, f0;
        s0 = seen_cnt;
        repeat (SKIP) send_frame();
        idle(4);
        check({tag, "_skipped_dip_count"}, seen_cnt - s0, 0);
        s0 = seen_cnt;
        f0 = fd_cnt;
        send_frame();
        idle(4);
        check({tag, "_captured_dip_count"}, seen_cnt - s0, 16);
        check({tag, "_frame_done_count"}, fd_cnt - f0, 1);
        check({tag, "_line_err"}, 32'(line_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d edges, expected completion", ecount);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] pl[$];
        logic [15:0] pa, pb;
        int          nl, np;
        bit          odd;

        vecs[0] = '{16'hFFFF, 8'd255};
        vecs[1] = '{16'hF800, 8'd76};
        vecs[2] = '{16'h07E0, 8'd149};
        vecs[3] = '{16'h001F, 8'd28};
        vecs[4] = '{16'h0000, 8'd0};

        rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_dip_en", 32'(dip_en), 32'd0);
        check("reset_dip_data", 32'(dip_data), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_line_err", 32'(line_err), 32'd0);
        rst = 1'b0;

        // Skip two frames, capture the third.
        run_skip_test("t1");

        // Known colours from the table, one line of five pixels.
        start_frame();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, vecs[i].pix[15:8]);
            step(1'b0, 1'b1, vecs[i].pix[7:0]);
            push_exp(vecs[i].gray, 1'b0);
        end
        model_line_end(5, 1'b0);
        idle(5);
        check("t2_long_line_err", 32'(line_err), 32'd1);

        // Odd byte count: one pixel, sticky error until the next vsync rise.
        start_frame();
        check("t3_err_cleared_on_vsync", 32'(line_err), 32'd0);
        pl = {16'($urandom)};
        send_line(pl, 1'b1);
        check("t3_odd_line_err", 32'(line_err), 32'(model_err));
        idle(6);
        check("t3_err_held", 32'(line_err), 32'd1);
        start_frame();
        check("t3_err_cleared", 32'(line_err), 32'd0);

        // vsync rise right after a high byte aborts that pixel only.
        pa = 16'($urandom);
        pb = 16'($urandom);
        step(1'b0, 1'b1, pa[15:8]);
        step(1'b0, 1'b1, pa[7:0]);
        push_exp(ref_gray(pa), 1'b0);
        step(1'b0, 1'b1, pb[15:8]);
        step(1'b1, 1'b1, pb[7:0]);
        model_rise();
        step(1'b1, 1'b0, 8'h00);
        model_line_end(0, 1'b0);
        idle(4);
        check("t4_abort_line_err", 32'(line_err), 32'(model_err));

        // Eight bytes back-to-back: four pixels two edges apart, clean line.
        start_frame();
        pl = {};
        repeat (COLS) pl.push_back(16'($urandom));
        send_line(pl, 1'b0);
        idle(2);
        check("t6_no_line_err", 32'(line_err), 32'd0);

        // Randomised frames: extra lines, short/long lines and dangling bytes.
        for (int f = 0; f < 4; f++) begin
            start_frame();
            nl = $urandom_range(ROWS + 1, ROWS);
            for (int l = 0; l < nl; l++) begin
                np  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 1)) : COLS;
                odd = ($urandom_range(5, 0) == 0);
                pl  = {};
                repeat (np) pl.push_back(16'($urandom));
                send_line(pl, odd);
            end
            idle(2);
            check("rand_frame_line_err", 32'(line_err), 32'(model_err));
        end

        // Reset mid-line of a captured frame; the in-flight pixel is lost.
        start_frame();
        pa = 16'hFFFF;
        pb = 16'($urandom);
        step(1'b0, 1'b1, pa[15:8]);
        step(1'b0, 1'b1, pa[7:0]);
        push_exp(ref_gray(pa), 1'b0);
        step(1'b0, 1'b1, pb[15:8]);
        step(1'b0, 1'b1, pb[7:0]);
        push_exp(ref_gray(pb), 1'b0);
        step(1'b0, 1'b1, 8'($urandom));
        @(negedge clk);
        rst = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].edge_n >= ecount + 1)
            void'(exp_q.pop_back());
        frames_seen = 0;
        line_idx    = 0;
        model_err   = 1'b0;
        @(posedge clk);
        #2;
        check("t5_rst_dip_en", 32'(dip_en), 32'd0);
        check("t5_rst_dip_data", 32'(dip_data), 32'd0);
        check("t5_rst_frame_done", 32'(frame_done), 32'd0);
        check("t5_rst_line_err", 32'(line_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cam_href = 1'b0;
        cam_data = 8'h00;
        run_skip_test("t5");

        idle(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
